// File: rtl/spi_seg_scan_ctrl_if.sv
// rtl/spi_seg_scan_ctrl_if.sv - SPI bus bundle between host and the segment/keypad controller
// Signals:
//   spi_sck   - SPI clock, mode 0 (host drives)
//   spi_mosi  - host-to-device data, MSB first
//   spi_cs_n  - chip select, active low (host drives)
//   spi_miso  - device-to-host data, MSB first (device drives)
// Modports: master = host side, slave = controller side.
interface spi_seg_scan_ctrl_if;
    logic spi_sck;
    logic spi_mosi;
    logic spi_cs_n;
    logic spi_miso;

    modport master (
        output spi_sck,
        output spi_mosi,
        output spi_cs_n,
        input  spi_miso
    );

    modport slave (
        input  spi_sck,
        input  spi_mosi,
        input  spi_cs_n,
        output spi_miso
    );
endinterface

// File: rtl/spi_seg_scan_ctrl.sv
// rtl/spi_seg_scan_ctrl.sv - SPI-slave multiplexed 7-segment display and keypad controller
// Optional feature macro: SPI_SEG_KEY_DEBOUNCE_EN (per-column key debounce counters).
// Ports:
//   clk          - system clock, at least 8x the SPI clock
//   rst_n        - asynchronous active-low reset
//   spi          - SPI slave bundle (sck, mosi, cs_n in; miso out)
//   key_col      - raw keypad columns, active high, asynchronous
//   seg_n        - segments {a,b,c,d,e,f,g}, active low
//   digit_sel_n  - digit select, walking zero
//   key_state    - conditioned key columns
// Frame: 8 bits while cs_n is low, {digit index[3:0], hex value[3:0]}; the keypad
// state is shifted out on miso during the same frame.
module spi_seg_scan_ctrl #(
    parameter int DIGITS      = 4,
    parameter int KEY_COLS    = 4,
    parameter int REFRESH_DIV = 1024,
    parameter int DEBOUNCE    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_seg_scan_ctrl_if.slave  spi,
    input  logic [KEY_COLS-1:0] key_col,
    output logic [6:0]          seg_n,
    output logic [DIGITS-1:0]   digit_sel_n,
    output logic [KEY_COLS-1:0] key_state
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (DIGITS < 1 || DIGITS > 16 || KEY_COLS < 1 || KEY_COLS > 8 ||
        REFRESH_DIV < 2 || DEBOUNCE < 1) begin : g_bad_params
        $error("spi_seg_scan_ctrl: parameter out of range");
    end

    // ------------------------------------------------------------------
    // Input synchronisers. The third stage of sck/cs_n is the "previous"
    // value for edge detection. cs_n resets to the asserted level so a
    // host still holding cs_n low across reset does not look like a new
    // frame start; a fresh falling edge is required.
    // ------------------------------------------------------------------
    logic [2:0] sck_ff;
    logic [2:0] cs_ff;
    logic [1:0] mosi_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_ff  <= '0;
            cs_ff   <= '0;
            mosi_ff <= '0;
        end else begin
            sck_ff  <= {sck_ff[1:0], spi.spi_sck};
            cs_ff   <= {cs_ff[1:0], spi.spi_cs_n};
            mosi_ff <= {mosi_ff[0], spi.spi_mosi};
        end
    end

    logic sck_rise, sck_fall, cs_fall, cs_rise, cs_low;
    assign sck_rise = sck_ff[1] & ~sck_ff[2];
    assign sck_fall = ~sck_ff[1] & sck_ff[2];
    assign cs_fall  = ~cs_ff[1] & cs_ff[2];
    assign cs_rise  = cs_ff[1] & ~cs_ff[2];
    assign cs_low   = ~cs_ff[1];

    // ------------------------------------------------------------------
    // SPI shift engine
    // ------------------------------------------------------------------
    logic [3:0] bit_cnt;
    logic [7:0] rx_sr;
    logic [7:0] tx_sr;
    logic       miso;
    logic [7:0] key_ext;

    always_comb begin
        key_ext                 = '0;
        key_ext[KEY_COLS-1:0]   = key_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            rx_sr   <= '0;
            tx_sr   <= '0;
            miso    <= 1'b0;
        end else if (cs_fall) begin
            bit_cnt <= '0;
            tx_sr   <= key_ext;
            miso    <= key_ext[7];
        end else if (cs_low) begin
            if (sck_rise) begin
                rx_sr <= {rx_sr[6:0], mosi_ff[1]};
                // Saturate at 9 so any overlong frame stays distinguishable from 8.
                if (bit_cnt != 4'd9) begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end
            if (sck_fall) begin
                tx_sr <= {tx_sr[6:0], 1'b0};
                miso  <= tx_sr[6];
            end
        end
    end

    assign spi.spi_miso = miso;

    logic commit;
    assign commit = cs_rise && (bit_cnt == 4'd8) && ({1'b0, rx_sr[7:4]} < 5'(DIGITS));

    // ------------------------------------------------------------------
    // Digit registers
    // ------------------------------------------------------------------
    logic [DIGITS-1:0] dig_valid;
    logic [3:0]        dig_val [DIGITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_valid <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                dig_val[i] <= '0;
            end
        end else if (commit) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (rx_sr[7:4] == 4'(i)) begin
                    dig_valid[i] <= 1'b1;
                    dig_val[i]   <= rx_sr[3:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Refresh scan
    // ------------------------------------------------------------------
    logic [RW-1:0] ref_cnt;
    logic [SW-1:0] slot;
    logic          tick;

    assign tick = (ref_cnt == RW'(REFRESH_DIV - 1));

    function automatic logic [6:0] hex_font_n(input logic [3:0] v);
        case (v)
            4'h0:    hex_font_n = 7'h01;
            4'h1:    hex_font_n = 7'h4F;
            4'h2:    hex_font_n = 7'h12;
            4'h3:    hex_font_n = 7'h06;
            4'h4:    hex_font_n = 7'h4C;
            4'h5:    hex_font_n = 7'h24;
            4'h6:    hex_font_n = 7'h20;
            4'h7:    hex_font_n = 7'h0F;
            4'h8:    hex_font_n = 7'h00;
            4'h9:    hex_font_n = 7'h04;
            4'hA:    hex_font_n = 7'h08;
            4'hB:    hex_font_n = 7'h60;
            4'hC:    hex_font_n = 7'h31;
            4'hD:    hex_font_n = 7'h42;
            4'hE:    hex_font_n = 7'h30;
            default: hex_font_n = 7'h38;
        endcase
    endfunction

    logic              cur_valid;
    logic [3:0]        cur_val;
    logic [DIGITS-1:0] sel_n_next;

    always_comb begin
        cur_valid  = 1'b0;
        cur_val    = '0;
        sel_n_next = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (slot == SW'(i)) begin
                cur_valid     = dig_valid[i];
                cur_val       = dig_val[i];
                sel_n_next[i] = 1'b0;
            end
        end
    end

    // On the terminal count the outputs blank for one clk while the slot
    // advances; the following clk drives the new slot from the digit
    // registers, so a commit landing on the same edge is already visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt     <= '0;
            slot        <= '0;
            seg_n       <= 7'h7F;
            digit_sel_n <= '1;
        end else if (tick) begin
            ref_cnt     <= '0;
            slot        <= (slot == SW'(DIGITS - 1)) ? '0 : slot + 1'b1;
            seg_n       <= 7'h7F;
            digit_sel_n <= '1;
        end else begin
            ref_cnt     <= ref_cnt + 1'b1;
            seg_n       <= cur_valid ? hex_font_n(cur_val) : 7'h7F;
            digit_sel_n <= sel_n_next;
        end
    end

    // ------------------------------------------------------------------
    // Key conditioning, sampled once per refresh terminal count
    // ------------------------------------------------------------------
    logic [KEY_COLS-1:0] key_ff0;
    logic [KEY_COLS-1:0] key_ff1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_ff0 <= '0;
            key_ff1 <= '0;
        end else begin
            key_ff0 <= key_col;
            key_ff1 <= key_ff0;
        end
    end

`ifdef SPI_SEG_KEY_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE + 1);
    logic [CW-1:0] deb_cnt [KEY_COLS];

    // A column counts samples that disagree with its accepted state; a
    // sample matching the accepted state breaks the run and clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_state <= '0;
            for (int c = 0; c < KEY_COLS; c++) begin
                deb_cnt[c] <= '0;
            end
        end else if (tick) begin
            for (int c = 0; c < KEY_COLS; c++) begin
                if (key_ff1[c] == key_state[c]) begin
                    deb_cnt[c] <= '0;
                end else if (deb_cnt[c] == CW'(DEBOUNCE - 1)) begin
                    key_state[c] <= key_ff1[c];
                    deb_cnt[c]   <= '0;
                end else begin
                    deb_cnt[c] <= deb_cnt[c] + 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_state <= '0;
        end else if (tick) begin
            key_state <= key_ff1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_seg_scan_ctrl.sv
// tb/tb_spi_seg_scan_ctrl.sv - self-checking bench for spi_seg_scan_ctrl
module tb_spi_seg_scan_ctrl;

    localparam int DIGITS   = 4;
    localparam int KEY_COLS = 4;
    localparam int R        = 32;
    localparam int DEB      = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [KEY_COLS-1:0] key_col;
    logic [6:0]          seg_n;
    logic [DIGITS-1:0]   digit_sel_n;
    logic [KEY_COLS-1:0] key_state;

    int n_checks = 0;
    int n_fail   = 0;

    bit         m_valid [DIGITS];
    logic [3:0] m_val   [DIGITS];

    spi_seg_scan_ctrl_if spi_bus ();

    spi_seg_scan_ctrl #(
        .DIGITS      (DIGITS),
        .KEY_COLS    (KEY_COLS),
        .REFRESH_DIV (R),
        .DEBOUNCE    (DEB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi         (spi_bus),
        .key_col     (key_col),
        .seg_n       (seg_n),
        .digit_sel_n (digit_sel_n),
        .key_state   (key_state)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected active-low pattern: lit segments a..g (MSB = a) per glyph, inverted.
    function automatic logic [6:0] exp_seg(input bit valid, input logic [3:0] v);
        logic [6:0] lit;
        case (v)
            4'h0: lit = 7'b1111110;
            4'h1: lit = 7'b0110000;
            4'h2: lit = 7'b1101101;
            4'h3: lit = 7'b1111001;
            4'h4: lit = 7'b0110011;
            4'h5: lit = 7'b1011011;
            4'h6: lit = 7'b1011111;
            4'h7: lit = 7'b1110000;
            4'h8: lit = 7'b1111111;
            4'h9: lit = 7'b1111011;
            4'hA: lit = 7'b1110111;
            4'hB: lit = 7'b0011111;
            4'hC: lit = 7'b1001110;
            4'hD: lit = 7'b0111101;
            4'hE: lit = 7'b1001111;
            default: lit = 7'b1000111;
        endcase
        return valid ? ~lit : 7'h7F;
    endfunction

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_clear();
        for (int i = 0; i < DIGITS; i++) begin
            m_valid[i] = 1'b0;
            m_val[i]   = 4'h0;
        end
    endtask

    // Host-side SPI frame at sck = clk/8; captures the first 8 miso bits.
    task automatic spi_xfer(input logic [15:0] data, input int nbits, output logic [7:0] miso_bits);
        int j;
        logic [7:0] frame;
        miso_bits = 8'h00;
        @(negedge clk);
        spi_bus.spi_cs_n = 1'b0;
        clk_n(4);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_bus.spi_mosi = data[i];
            clk_n(4);
            j = nbits - 1 - i;
            if (j < 8) miso_bits[7 - j] = spi_bus.spi_miso;
            spi_bus.spi_sck = 1'b1;
            clk_n(4);
            spi_bus.spi_sck = 1'b0;
        end
        clk_n(4);
        spi_bus.spi_cs_n = 1'b1;
        clk_n(6);
        frame = data[7:0];
        if (nbits == 8 && int'(frame[7:4]) < DIGITS) begin
            m_valid[frame[7:4]] = 1'b1;
            m_val[frame[7:4]]   = frame[3:0];
        end
    endtask

    task automatic wait_blank();
        int n;
        n = 0;
        @(negedge clk);
        while (digit_sel_n !== '1 && n < 2 * R) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (digit_sel_n !== '1) begin
            n_fail++;
            $display("FAIL wait_blank: no blanking cycle within %0d clks, sel=%h", 2 * R, digit_sel_n);
        end
    endtask

    // Watches more than one full scan and checks every cycle against the model.
    task automatic scan_check(input string tag);
        int last_k, blank_run, k;
        logic [DIGITS-1:0] onehot_n;
        logic [6:0] e;
        last_k = -1;
        blank_run = 0;
        repeat ((DIGITS + 1) * R) begin
            @(negedge clk);
            if (digit_sel_n === '1) begin
                blank_run++;
                n_checks++;
                if (seg_n !== 7'h7F) begin
                    n_fail++;
                    $display("FAIL %s blank_seg: seg_n=%h expected 7f", tag, seg_n);
                end
            end else begin
                k = -1;
                for (int i = 0; i < DIGITS; i++) if (digit_sel_n[i] === 1'b0 && k < 0) k = i;
                onehot_n = '1;
                if (k >= 0) onehot_n[k] = 1'b0;
                n_checks++;
                if (k < 0 || digit_sel_n !== onehot_n) begin
                    n_fail++;
                    $display("FAIL %s select: digit_sel_n=%h not a single zero", tag, digit_sel_n);
                end else begin
                    e = exp_seg(m_valid[k], m_val[k]);
                    n_checks++;
                    if (seg_n !== e) begin
                        n_fail++;
                        $display("FAIL %s seg slot%0d: seg_n=%h expected %h", tag, k, seg_n, e);
                    end
                    if (k != last_k) begin
                        if (last_k >= 0) begin
                            n_checks++;
                            if (k != (last_k + 1) % DIGITS) begin
                                n_fail++;
                                $display("FAIL %s order: slot %0d after %0d expected %0d", tag, k, last_k, (last_k + 1) % DIGITS);
                            end
                            n_checks++;
                            if (blank_run != 1) begin
                                n_fail++;
                                $display("FAIL %s blank_len: %0d clks expected 1", tag, blank_run);
                            end
                        end
                        last_k = k;
                    end
                end
                blank_run = 0;
            end
        end
    endtask

    task automatic test_reset();
        spi_bus.spi_sck  = 1'b0;
        spi_bus.spi_mosi = 1'b0;
        spi_bus.spi_cs_n = 1'b1;
        key_col = '0;
        rst_n = 1'b0;
        model_clear();
        clk_n(3);
        n_checks++;
        if (seg_n !== 7'h7F) begin n_fail++; $display("FAIL reset seg_n: got %h expected 7f", seg_n); end
        n_checks++;
        if (digit_sel_n !== 4'hF) begin n_fail++; $display("FAIL reset digit_sel_n: got %h expected f", digit_sel_n); end
        n_checks++;
        if (key_state !== 4'h0) begin n_fail++; $display("FAIL reset key_state: got %h expected 0", key_state); end
        n_checks++;
        if (spi_bus.spi_miso !== 1'b0) begin n_fail++; $display("FAIL reset miso: got %b expected 0", spi_bus.spi_miso); end
        rst_n = 1'b1;
        scan_check("reset_scan");
    endtask

    task automatic test_display();
        logic [7:0] mb;
        spi_xfer(16'h05, 8, mb);
        spi_xfer(16'h1A, 8, mb);
        spi_xfer(16'h2C, 8, mb);
        spi_xfer(16'h3F, 8, mb);
        scan_check("display");
    endtask

    task automatic test_bad_frames();
        logic [7:0] mb;
        spi_xfer(16'h0004, 7, mb);      // 7-bit frame aimed at digit 0
        spi_xfer(16'h0013, 9, mb);      // 9-bit frame, last 8 bits would address digit 1
        spi_xfer(16'h0048, 8, mb);      // index beyond DIGITS
        scan_check("bad_frames");
    endtask

    task automatic test_random_frames();
        logic [7:0] mb;
        logic [15:0] d;
        int nb;
        for (int t = 0; t < 10; t++) begin
            d  = 16'($urandom_range(0, 16'hFFFF));
            d[7]  = ($urandom_range(0, 3) == 0);
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 10)) : 8;
            spi_xfer(d, nb, mb);
        end
        scan_check("random_frames");
    endtask

    task automatic test_keys();
        logic [7:0] mb;
        logic [3:0] old_k, new_k, mid_exp;
        key_col = 4'b0100;
        clk_n((DEB + 2) * R);
        n_checks++;
        if (key_state !== 4'b0100) begin n_fail++; $display("FAIL key_hold: key_state=%b expected 0100", key_state); end
        spi_xfer(16'h0F, 8, mb);
        n_checks++;
        if (mb !== 8'h04) begin n_fail++; $display("FAIL key_miso: got %b expected 00000100", mb); end
        old_k = 4'b0100;
        for (int t = 0; t < 4; t++) begin
            new_k = 4'($urandom_range(0, 15));
            wait_blank();
            key_col = new_k;
`ifdef SPI_SEG_KEY_DEBOUNCE_EN
            mid_exp = old_k;
`else
            mid_exp = new_k;
`endif
            clk_n((DEB - 1) * R + R / 2);
            n_checks++;
            if (key_state !== mid_exp) begin n_fail++; $display("FAIL key_mid[%0d]: key_state=%b expected %b", t, key_state, mid_exp); end
            clk_n(R);
            n_checks++;
            if (key_state !== new_k) begin n_fail++; $display("FAIL key_settled[%0d]: key_state=%b expected %b", t, key_state, new_k); end
            spi_xfer(16'($urandom_range(0, 16'h3F)), 8, mb);
            n_checks++;
            if (mb !== {4'b0000, new_k}) begin n_fail++; $display("FAIL key_miso[%0d]: got %b expected %b", t, mb, {4'b0000, new_k}); end
            old_k = new_k;
        end
        scan_check("after_keys");
    endtask

    task automatic test_debounce_pulse();
        logic [3:0] during_exp;
        key_col = 4'b0000;
        clk_n((DEB + 2) * R);
        n_checks++;
        if (key_state !== 4'b0000) begin n_fail++; $display("FAIL pulse_pre: key_state=%b expected 0000", key_state); end
        wait_blank();
        key_col = 4'b0010;
`ifdef SPI_SEG_KEY_DEBOUNCE_EN
        during_exp = 4'b0000;
`else
        during_exp = 4'b0010;
`endif
        clk_n(R + R / 2);
        n_checks++;
        if (key_state !== during_exp) begin n_fail++; $display("FAIL pulse_mid: key_state=%b expected %b", key_state, during_exp); end
        clk_n((DEB - 1) * R - (R + R / 2));
        key_col = 4'b0000;
        n_checks++;
        if (key_state !== during_exp) begin n_fail++; $display("FAIL pulse_end: key_state=%b expected %b", key_state, during_exp); end
        clk_n(3 * R);
        n_checks++;
        if (key_state !== 4'b0000) begin n_fail++; $display("FAIL pulse_post: key_state=%b expected 0000", key_state); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] mb;
        logic [7:0] d;
        d = 8'h17;
        @(negedge clk);
        spi_bus.spi_cs_n = 1'b0;
        clk_n(4);
        for (int i = 7; i >= 4; i--) begin
            spi_bus.spi_mosi = d[i];
            clk_n(4);
            spi_bus.spi_sck = 1'b1;
            clk_n(4);
            spi_bus.spi_sck = 1'b0;
        end
        clk_n(2);
        rst_n = 1'b0;
        model_clear();
        clk_n(2);
        spi_bus.spi_cs_n = 1'b1;
        clk_n(2);
        n_checks++;
        if (digit_sel_n !== 4'hF || seg_n !== 7'h7F) begin
            n_fail++;
            $display("FAIL midreset outputs: sel=%h seg=%h expected f/7f", digit_sel_n, seg_n);
        end
        rst_n = 1'b1;
        clk_n(4);
        spi_xfer(16'h07, 8, mb);
        scan_check("after_midreset");
    endtask

    initial begin
        test_reset();
        test_display();
        test_bad_frames();
        test_random_frames();
        test_keys();
        test_debounce_pulse();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
